// File: rtl/sr_input_conditioner.sv
// rtl/sr_input_conditioner.sv - synchronise, debounce and edge-detect two buttons into exclusive S/R pulses
// Channel index 0 is the set button, index 1 the reset button.
module sr_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int PULSE_CYCLES    = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic set_btn,
   input  logic reset_btn,
   output logic S,
   output logic R,
   output logic busy,
   output logic conflict
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
   localparam int PC_W = $clog2(PULSE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [PC_W-1:0] PC_MAX = PC_W'(PULSE_CYCLES);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SET_P = 2'd1,
      RST_P = 2'd2
   } state_t;

   logic [1:0]      btn_raw;
   logic [1:0]      sync1_q, sync1_d;
   logic [1:0]      sync2_q, sync2_d;
   logic [1:0]      stable_q, stable_d;
   logic [1:0]      prev_q, prev_d;
   logic [1:0]      evt;
   logic [DB_W-1:0] cnt_q [2];
   logic [DB_W-1:0] cnt_d [2];

   state_t          state_q, state_d;
   logic [PC_W-1:0] pcnt_q, pcnt_d;
   logic            s_q, s_d;
   logic            r_q, r_d;
   logic            busy_q, busy_d;
   logic            conflict_q, conflict_d;

   assign btn_raw = {reset_btn, set_btn};

   // Any sample matching the stable level restarts the count.
   always_comb begin
      sync1_d  = btn_raw;
      sync2_d  = sync1_q;
      stable_d = stable_q;
      prev_d   = stable_q;
      for (int i = 0; i < 2; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == DB_MAX) begin
               stable_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + DB_W'(1);
            end
         end
      end
      evt = stable_q & ~prev_q;
   end

   always_comb begin
      state_d    = state_q;
      pcnt_d     = pcnt_q;
      s_d        = 1'b0;
      r_d        = 1'b0;
      busy_d     = 1'b0;
      conflict_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (evt[0] && evt[1]) begin
               conflict_d = 1'b1;
            end else if (evt[0]) begin
               state_d = SET_P;
               s_d     = 1'b1;
               busy_d  = 1'b1;
               pcnt_d  = PC_W'(1);
            end else if (evt[1]) begin
               state_d = RST_P;
               r_d     = 1'b1;
               busy_d  = 1'b1;
               pcnt_d  = PC_W'(1);
            end
         end
         SET_P, RST_P: begin
            // Events seen here are dropped, never queued.
            if (pcnt_q < PC_MAX) begin
               pcnt_d = pcnt_q + PC_W'(1);
               s_d    = (state_q == SET_P);
               r_d    = (state_q == RST_P);
               busy_d = 1'b1;
            end else begin
               state_d = IDLE;
               pcnt_d  = '0;
            end
         end
         default: begin
            state_d = IDLE;
            pcnt_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         stable_q   <= '0;
         prev_q     <= '0;
         cnt_q[0]   <= '0;
         cnt_q[1]   <= '0;
         state_q    <= IDLE;
         pcnt_q     <= '0;
         s_q        <= 1'b0;
         r_q        <= 1'b0;
         busy_q     <= 1'b0;
         conflict_q <= 1'b0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         stable_q   <= stable_d;
         prev_q     <= prev_d;
         cnt_q[0]   <= cnt_d[0];
         cnt_q[1]   <= cnt_d[1];
         state_q    <= state_d;
         pcnt_q     <= pcnt_d;
         s_q        <= s_d;
         r_q        <= r_d;
         busy_q     <= busy_d;
         conflict_q <= conflict_d;
      end
   end

   assign S        = s_q;
   assign R        = r_q;
   assign busy     = busy_q;
   assign conflict = conflict_q;

endmodule

// File: doc/sr_input_conditioner.md
# sr_input_conditioner

Front-end stage that drives the active-high S/R inputs of the board's SR latch / flip-flop demos from two raw push-buttons. Each button is synchronised, debounced, and edge-detected, and each press becomes a clean, fixed-width, registered S or R pulse. The block guarantees that S and R are never high together, so the downstream latch never sees the forbidden S=R=1 input.

## Interface
- DEBOUNCE_CYCLES, 500000, consecutive cycles an input must hold a new level before it is accepted; minimum 2 (10 ms at 50 MHz).
- PULSE_CYCLES, 1, width of each S/R output pulse in clock cycles; minimum 1.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- set_btn  input  1  raw, asynchronous, bouncing set button; active high.
- reset_btn  input  1  raw, asynchronous, bouncing reset button; active high.
- S  output  1  registered set pulse to the latch.
- R  output  1  registered reset pulse to the latch.
- busy  output  1  registered; high while an S or R pulse is in progress.
- conflict  output  1  registered; one-cycle pulse when set and reset presses are accepted in the same cycle.

## Operation
- Each channel (set, reset) has identical logic: 2-FF synchroniser, then a debouncer, then a rising-edge detector.
- Debouncer state:
  - one stable-level register, reset value 0;
  - one counter of width $clog2(DEBOUNCE_CYCLES), reset value 0.
- Debouncer rules, evaluated every cycle:
  - synced input == stable: counter <= 0.
  - synced != stable and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - synced != stable and counter == DEBOUNCE_CYCLES-1: stable <= synced, counter <= 0.
  - Any bounce back to the stable level restarts the count from 0.
- Press event: combinational stable & ~stable_prev, where stable_prev is a register with reset value 0. It is high for exactly one cycle per accepted rising level. Releases (falling edges) generate nothing.
- Pulse FSM: states IDLE, SET_P, RST_P; pulse counter of width $clog2(PULSE_CYCLES+1).
- IDLE transitions:
  - set_evt & reset_evt: conflict <= 1 for one cycle, stay IDLE, no pulse.
  - set_evt only: go to SET_P, S <= 1, busy <= 1, pulse counter <= 1.
  - reset_evt only: go to RST_P, R <= 1, busy <= 1, pulse counter <= 1.
- SET_P / RST_P transitions:
  - pulse counter < PULSE_CYCLES: increment the counter, hold the output.
  - pulse counter == PULSE_CYCLES: drop S/R and busy, return to IDLE.
- Events arriving while busy are discarded, not queued. This includes an opposite-channel event.
- Invariant: S & R == 0 in every cycle.
- Reset values: S=0, R=0, busy=0, conflict=0, FSM=IDLE, all counters, stable and stable_prev registers 0, synchroniser flops 0.
- Reset mid-operation: all outputs drop on the clock edge that samples rst=1. An in-flight pulse is truncated and never resumed.
- A button still held when rst deasserts is re-debounced from 0. It produces a normal press event DEBOUNCE_CYCLES+2 edges after release of reset.

## Timing
- Reference point: let edge k be the first clock edge that samples set_btn=1, with the button held clean from then on.
  - Synchroniser output is high after edge k+1.
  - stable goes high at edge k+DEBOUNCE_CYCLES+1.
  - S is first high after edge k+DEBOUNCE_CYCLES+2.
- Latency from first sample to output: DEBOUNCE_CYCLES+2 cycles. The same applies to R.
- Pulse width: S/R and busy are high for exactly PULSE_CYCLES consecutive cycles.
- Back-to-back: the earliest next pulse can start the cycle after busy falls.
- conflict goes high one edge after the simultaneous events; S and R both stay 0.
- Every output is driven directly from a flop; there are no combinational paths from inputs to outputs.

## Test plan
Parameters for all scenarios: DEBOUNCE_CYCLES=4, PULSE_CYCLES=3.
- Clean press: set_btn rises, sampled first at edge 10, held → S high after edges 16, 17, 18; low after edge 19; busy identical; R=0 throughout.
- Bounce: set_btn toggles 1,0,1,0 on consecutive cycles, then holds 1 from edge 20 → exactly one S pulse, first high after edge 26; no earlier activity.
- Simultaneous: both buttons rise, sampled first at the same edge 10, held → conflict high only after edge 16; S=R=0 for the whole test; busy=0.
- Overlap drop: set accepted (S high after edge 16); reset_btn press timed so its event lands during SET_P → no R pulse ever; a later reset press after busy falls → normal 3-cycle R pulse.
- Reset mid-pulse: assert rst for the edge after S first goes high → S, busy, FSM, and counters all 0 after that edge. With set_btn still held, a new S pulse starts 6 edges after rst deasserts.
- Release and short glitch: a 3-cycle high glitch on reset_btn → no R. A long release of a held button → no output. Check the S&R==0 assertion on every cycle.
